// File: rtl/or_array_arbiter_pkg.sv
// Shared constants and FSM state encoding for the OR-array arbiter.
package or_array_arbiter_pkg;
  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int ID_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_RESP = 2'b10
  } state_t;
endpackage

// File: rtl/or_array_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set req bit searching upward from ptr, modulo 4.
module rr_pick4
  import or_array_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] winner
);
  logic [ID_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set bit is the last to overwrite.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = ptr + ID_W'(i);
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end
endmodule

// File: rtl/or_array_arbiter.sv
// Four requesters share one registered 16-bit OR stage; round-robin grant, one-cycle ack to the winner.
module or_array_arbiter
  import or_array_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_bus,
  input  logic [NREQ*WIDTH-1:0] b_bus,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      result,
  output logic                  out_valid,
  output logic [ID_W-1:0]       out_id,
  output logic                  busy,
  output state_t                state
);
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             found;
  logic [ID_W-1:0]  winner;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr),
    .found  (found),
    .winner (winner)
  );

  assign busy = (state != S_IDLE);

  // ack/out_valid are set on the BUSY->RESP edge so they are high exactly while in RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      win_id    <= '0;
      grant     <= '0;
      ack       <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      result    <= '0;
      op_a      <= '0;
      op_b      <= '0;
    end else begin
      ack       <= '0;
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant  <= NREQ'(1) << winner;
            win_id <= winner;
            op_a   <= a_bus[winner*WIDTH +: WIDTH];
            op_b   <= b_bus[winner*WIDTH +: WIDTH];
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          result      <= op_a | op_b;
          ack[win_id] <= 1'b1;
          out_valid   <= 1'b1;
          out_id      <= win_id;
          state       <= S_RESP;
        end
        S_RESP: begin
          ptr   <= win_id + ID_W'(1);
          grant <= '0;
          state <= S_IDLE;
        end
        default: begin
          grant <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
